breakout_game_ctrl: RTL and testbench

- Top-level sequencer for the paddle and ball datapath: game state machine, life counter, serve countdown and rate-limited paddle move strobes.
- Drives the paddle block's pause, move_left and move_right inputs, and requests a recentre through the paddle's reset.
- Issues the ball-launch pulse.
- Consumes one-cycle event pulses from the ball/collision logic and the button conditioners.

---
 rtl/breakout_pkg.sv | 24 ++
 rtl/move_tick_gen.sv | 34 +++
 rtl/breakout_game_ctrl.sv | 156 +++++++++++++++
 tb/tb_breakout_game_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/breakout_pkg.sv
// Shared types and default constants for the breakout game controller.
package breakout_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SERVE  = 3'd1,
    ST_PLAY   = 3'd2,
    ST_PAUSED = 3'd3,
    ST_MISS   = 3'd4,
    ST_LOST   = 3'd5,
    ST_WON    = 3'd6
  } state_e;

  localparam int unsigned LIVES_W          = 4;
  localparam int unsigned MOVE_DIV_DEF     = 4;
  localparam int unsigned SERVE_CYCLES_DEF = 16;
  localparam int unsigned LIVES_INIT_DEF   = 3;

  // Counter width for a modulus of n; at least one bit so n=1 still elaborates.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/move_tick_gen.sv
// Paddle move-rate divider: counts 0..DIV-1 while run is high, holds otherwise.
module move_tick_gen
  import breakout_pkg::*;
#(
  parameter int unsigned DIV = MOVE_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clr,
  output logic tc
);

  localparam int unsigned W = cnt_width(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tc    = run && (cnt_q == LAST);
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/breakout_game_ctrl.sv
// Game sequencer for the paddle/ball datapath: states, lives, serve countdown, move strobes.
// Define AUTO_SERVE_EN to launch the ball automatically when the serve countdown expires.
//
// state  | meaning
// IDLE   | waiting for first start
// SERVE  | paddle recentred, countdown running, waiting to launch
// PLAY   | ball in motion, paddle moves enabled
// PAUSED | play frozen, move divider held
// MISS   | one cycle: consume a life
// LOST   | no lives left, waiting for start
// WON    | all bricks cleared, waiting for start
module breakout_game_ctrl
  import breakout_pkg::*;
#(
  parameter int unsigned MOVE_DIV     = MOVE_DIV_DEF,
  parameter int unsigned SERVE_CYCLES = SERVE_CYCLES_DEF,
  parameter int unsigned LIVES_INIT   = LIVES_INIT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               start_p,
  input  logic               pause_p,
  input  logic               miss_p,
  input  logic               cleared_p,
  output logic               move_left,
  output logic               move_right,
  output logic               paddle_pause,
  output logic               paddle_recentre,
  output logic               ball_launch,
  output logic [LIVES_W-1:0] lives,
  output logic [2:0]         state,
  output logic               game_over,
  output logic               win
);

  localparam int unsigned CW = cnt_width(SERVE_CYCLES);
  localparam logic [CW-1:0]      CD_LOAD = CW'(SERVE_CYCLES - 1);
  localparam logic [LIVES_W-1:0] LV_LOAD = LIVES_W'(LIVES_INIT);

  state_e             state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [CW-1:0]      cd_q, cd_d;
  logic               pause_q, pause_d;
  logic               recentre_q, recentre_d;
  logic               launch_q, launch_d;
  logic               left_q, left_d;
  logic               right_q, right_d;
  logic               over_q, over_d;
  logic               win_q, win_d;
  logic               tick_tc;
  logic               serve_entry;
  logic               play_hold;

  move_tick_gen #(.DIV(MOVE_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .run   (state_q == ST_PLAY),
    .clr   (launch_d),
    .tc    (tick_tc)
  );

  always_comb begin
    state_d  = state_q;
    lives_d  = lives_q;
    cd_d     = cd_q;
    launch_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_p) begin
          state_d = ST_SERVE;
          lives_d = LV_LOAD;
        end
      end
      ST_SERVE: begin
`ifdef AUTO_SERVE_EN
        launch_d = (cd_q == '0);
`else
        launch_d = (cd_q == '0) && start_p;
`endif
        if (launch_d)        state_d = ST_PLAY;
        else if (cd_q != '0) cd_d = cd_q - 1'b1;
      end
      ST_PLAY: begin
        if (cleared_p)    state_d = ST_WON;
        else if (miss_p)  state_d = ST_MISS;
        else if (pause_p) state_d = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (pause_p) state_d = ST_PLAY;
      end
      ST_MISS: begin
        if (lives_q != '0) lives_d = lives_q - 1'b1;
        state_d = (lives_q <= LIVES_W'(1)) ? ST_LOST : ST_SERVE;
      end
      ST_LOST, ST_WON: begin
        if (start_p) begin
          state_d = ST_SERVE;
          lives_d = LV_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    serve_entry = (state_d == ST_SERVE) && (state_q != ST_SERVE);
    if (serve_entry) cd_d = CD_LOAD;

    // Strobe only when PLAY persists, so no strobe lands in a state being entered.
    play_hold  = (state_q == ST_PLAY) && (state_d == ST_PLAY);
    left_d     = play_hold && tick_tc && btn_left && !btn_right;
    right_d    = play_hold && tick_tc && btn_right && !btn_left;
    pause_d    = (state_q != ST_PLAY);
    recentre_d = serve_entry;
    over_d     = (state_d == ST_LOST) || (state_d == ST_WON);
    win_d      = (state_d == ST_WON);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      lives_q    <= '0;
      cd_q       <= '0;
      pause_q    <= 1'b1;
      recentre_q <= 1'b0;
      launch_q   <= 1'b0;
      left_q     <= 1'b0;
      right_q    <= 1'b0;
      over_q     <= 1'b0;
      win_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lives_q    <= lives_d;
      cd_q       <= cd_d;
      pause_q    <= pause_d;
      recentre_q <= recentre_d;
      launch_q   <= launch_d;
      left_q     <= left_d;
      right_q    <= right_d;
      over_q     <= over_d;
      win_q      <= win_d;
    end
  end

  assign state           = state_q;
  assign lives           = lives_q;
  assign paddle_pause    = pause_q;
  assign paddle_recentre = recentre_q;
  assign ball_launch     = launch_q;
  assign move_left       = left_q;
  assign move_right      = right_q;
  assign game_over       = over_q;
  assign win             = win_q;

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Bench for breakout_game_ctrl: directed stimulus, pulse outputs checked from an expectation queue.
module tb_breakout_game_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_left = 1'b0, btn_right = 1'b0;
  logic       start_p = 1'b0, pause_p = 1'b0, miss_p = 1'b0, cleared_p = 1'b0;
  logic       move_left, move_right, paddle_pause, paddle_recentre, ball_launch;
  logic [3:0] lives;
  logic [2:0] state;
  logic       game_over, win;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] ev;
    logic [2:0] st;
    logic [3:0] lv;
  } exp_t;

  exp_t exp_q[$];

  localparam logic [3:0] EV_RC = 4'b1000;
  localparam logic [3:0] EV_LA = 4'b0100;
  localparam logic [3:0] EV_ML = 4'b0010;

  localparam logic [3:0] P_START = 4'b1000;
  localparam logic [3:0] P_PAUSE = 4'b0100;
  localparam logic [3:0] P_MISS  = 4'b0010;
  localparam logic [3:0] P_CLR   = 4'b0001;

  breakout_game_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .btn_left        (btn_left),
    .btn_right       (btn_right),
    .start_p         (start_p),
    .pause_p         (pause_p),
    .miss_p          (miss_p),
    .cleared_p       (cleared_p),
    .move_left       (move_left),
    .move_right      (move_right),
    .paddle_pause    (paddle_pause),
    .paddle_recentre (paddle_recentre),
    .ball_launch     (ball_launch),
    .lives           (lives),
    .state           (state),
    .game_over       (game_over),
    .win             (win)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  // Monitor: every pulse output seen is matched against the next expected event.
  always @(negedge clk) begin
    logic [3:0] ev;
    exp_t e;
    if (!reset) begin
      ev = {paddle_recentre, ball_launch, move_left, move_right};
      if (ev != 4'b0000) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event got ev=%b st=%0d lv=%0d want none", ev, state, lives);
        end else begin
          e = exp_q.pop_front();
          if (ev !== e.ev || state !== e.st || lives !== e.lv) begin
            bad++;
            $display("FAIL event got ev=%b st=%0d lv=%0d want ev=%b st=%0d lv=%0d",
                     ev, state, lives, e.ev, e.st, e.lv);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [3:0] m);
    {start_p, pause_p, miss_p, cleared_p} = m;
    tick(1);
    {start_p, pause_p, miss_p, cleared_p} = 4'b0000;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic expect_ev(input logic [3:0] ev, input logic [2:0] st, input logic [3:0] lv);
    exp_t e;
    e.ev = ev;
    e.st = st;
    e.lv = lv;
    exp_q.push_back(e);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_lives"}, 32'(lives), 0);
    chk({tag, "_pause"}, 32'(paddle_pause), 1);
    chk({tag, "_strobes"}, 32'({paddle_recentre, ball_launch, move_left, move_right}), 0);
    chk({tag, "_over_win"}, 32'({game_over, win}), 0);
  endtask

  // Entered at the first SERVE cycle; leaves at the second PLAY cycle.
  task automatic serve_launch(input logic [3:0] lv);
    expect_ev(EV_LA, 3'd2, lv);
    tick(4);
    pulse(P_START);
    chk("serve_start_early", 32'(state), 1);
    tick(9);
    pulse(P_START);
    chk("serve_start_cd1", 32'(state), 1);
`ifdef AUTO_SERVE_EN
    tick(1);
`else
    pulse(P_START);
`endif
    chk("launch_state", 32'(state), 2);
    chk("launch_pulse", 32'(ball_launch), 1);
    chk("launch_pause_hi", 32'(paddle_pause), 1);
    tick(1);
    chk("play_pause_lo", 32'(paddle_pause), 0);
    chk("launch_done", 32'(ball_launch), 0);
  endtask

  initial begin
    tick(2);
    chk_reset_vals("reset");
    reset = 1'b0;
    tick(1);
    chk("idle_hold", 32'(state), 0);

    expect_ev(EV_RC, 3'd1, 4'd3);
    pulse(P_START);
    chk("start_state", 32'(state), 1);
    chk("start_lives", 32'(lives), 3);
    chk("start_recentre", 32'(paddle_recentre), 1);
    serve_launch(4'd3);

    // Left held 20 cycles from tick count 1: terminal counts land 5 times.
    btn_left = 1'b1;
    repeat (5) expect_ev(EV_ML, 3'd2, 4'd3);
    tick(20);
    btn_left = 1'b0;
    chk("left_count", 32'(exp_q.size()), 0);

    btn_left  = 1'b1;
    btn_right = 1'b1;
    tick(8);
    btn_left  = 1'b0;
    btn_right = 1'b0;
    chk("both_held", 32'(exp_q.size()), 0);

    // Pause sampled with tick count 2; divider holds at 3 until resume.
    tick(1);
    btn_left = 1'b1;
    pulse(P_PAUSE);
    chk("paused_state", 32'(state), 3);
    tick(1);
    chk("paused_pause", 32'(paddle_pause), 1);
    pulse(P_START | P_MISS | P_CLR);
    chk("paused_ignore_state", 32'(state), 3);
    chk("paused_ignore_lives", 32'(lives), 3);
    tick(7);
    chk("paused_quiet", 32'(exp_q.size()), 0);
    expect_ev(EV_ML, 3'd2, 4'd3);
    pulse(P_PAUSE);
    chk("resume_state", 32'(state), 2);
    chk("resume_no_strobe_yet", 32'(move_left), 0);
    tick(1);
    chk("resume_strobe", 32'(move_left), 1);
    btn_left = 1'b0;
    tick(1);
    chk("resume_drained", 32'(exp_q.size()), 0);

    expect_ev(EV_RC, 3'd1, 4'd2);
    pulse(P_MISS);
    chk("miss1_state", 32'(state), 4);
    chk("miss1_lives_pre", 32'(lives), 3);
    tick(1);
    chk("miss1_serve", 32'(state), 1);
    chk("miss1_lives", 32'(lives), 2);
    serve_launch(4'd2);

    expect_ev(EV_RC, 3'd1, 4'd1);
    pulse(P_MISS);
    tick(1);
    chk("miss2_lives", 32'(lives), 1);
    serve_launch(4'd1);

    pulse(P_MISS);
    chk("miss3_state", 32'(state), 4);
    tick(1);
    chk("lost_state", 32'(state), 5);
    chk("lost_lives", 32'(lives), 0);
    chk("lost_over", 32'(game_over), 1);
    chk("lost_win", 32'(win), 0);
    pulse(P_MISS);
    tick(2);
    chk("lost_no_underflow", 32'(lives), 0);
    chk("lost_hold", 32'(state), 5);

    expect_ev(EV_RC, 3'd1, 4'd3);
    pulse(P_START);
    chk("restart_state", 32'(state), 1);
    chk("restart_lives", 32'(lives), 3);
    chk("restart_over", 32'(game_over), 0);
    serve_launch(4'd3);

    pulse(P_MISS | P_CLR);
    chk("won_state", 32'(state), 6);
    chk("won_win", 32'(win), 1);
    chk("won_over", 32'(game_over), 1);
    chk("won_lives", 32'(lives), 3);
    tick(2);
    chk("won_pause", 32'(paddle_pause), 1);

    expect_ev(EV_RC, 3'd1, 4'd3);
    pulse(P_START);
    serve_launch(4'd3);
    tick(3);
    reset = 1'b1;
    tick(1);
    chk_reset_vals("rst_play");
    reset = 1'b0;
    tick(1);

    expect_ev(EV_RC, 3'd1, 4'd3);
    pulse(P_START);
    tick(5);
    reset = 1'b1;
    tick(1);
    chk_reset_vals("rst_serve");
    reset = 1'b0;
    tick(1);

    expect_ev(EV_RC, 3'd1, 4'd3);
    pulse(P_START);
    serve_launch(4'd3);
    tick(2);
    chk("final_drained", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
